// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_ctrl
//  Description : Assembles fixed-length multi-byte frames from a UART receiver,
//                replies ACK/NAK through the UART transmitter, and commits the
//                last good frame to the output on a rising edge of shoot.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl #(
    parameter int         NUM_BYTES      = 2,
    parameter int         STARTUP_CYCLES = 24000000,
    parameter int         TIMEOUT_CYCLES = 2400,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shoot,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   rx_parity_err,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [8*NUM_BYTES-1:0] value,
    output logic                   value_valid,
    output logic [7:0]             err_cnt,
    output logic                   armed
);

    // Counter widths hold the full terminal value; +2 keeps the width >= 1
    localparam int c_SU_W  = $clog2(STARTUP_CYCLES + 2);
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam int c_IDX_W = $clog2(NUM_BYTES + 1);

    localparam logic [c_SU_W-1:0]  c_SU_LAST  = c_SU_W'(STARTUP_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RECV    = 2'd1,
        ST_REPLY   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_SU_W-1:0]        r_su_cnt;
    logic [c_TMR_W-1:0]       r_tmr;
    logic [c_IDX_W-1:0]       r_idx;
    logic [8*NUM_BYTES-1:0]   r_shadow;
    logic                     r_shoot_d;
    logic                     r_ack;

    logic                     w_su_done;
    logic                     w_timeout;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_nak;
    logic                     w_err_inc;
    logic                     w_commit;

    assign armed = (r_state != ST_STARTUP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle event strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_nak        = 1'b0;
        w_err_inc    = 1'b0;
        w_commit     = 1'b0;
        tx_start     = 1'b0;
        w_su_done    = (r_su_cnt == c_SU_LAST);
        w_timeout    = (r_idx != '0) && (r_tmr == c_TMR_LAST);
        case (r_state)
            ST_STARTUP: begin
                if (w_su_done && shoot) begin
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                // A received byte wins over a timer expiring in the same cycle
                if (rx_done) begin
                    if (rx_parity_err) begin
                        w_nak        = 1'b1;
                        w_err_inc    = 1'b1;
                        w_state_next = ST_REPLY;
                    end else begin
                        w_accept = 1'b1;
                        if (r_idx == c_IDX_LAST) begin
                            w_last       = 1'b1;
                            w_state_next = ST_REPLY;
                        end
                    end
                end else if (w_timeout) begin
                    w_nak        = 1'b1;
                    w_err_inc    = 1'b1;
                    w_state_next = ST_REPLY;
                end
            end
            ST_REPLY: begin
                w_err_inc = rx_done;
                if (!tx_busy) begin
                    tx_start     = 1'b1;
                    w_state_next = r_ack ? ST_HOLD : ST_RECV;
                end
            end
            ST_HOLD: begin
                w_err_inc = rx_done;
                if (shoot && !r_shoot_d) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_RECV;
                end
            end
            default: begin
                w_state_next = ST_STARTUP;
            end
        endcase
    end

    // Datapath: counters, shadow frame, reply byte, committed value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_su_cnt    <= '0;
            r_tmr       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_shoot_d   <= 1'b0;
            r_ack       <= 1'b0;
            tx_data     <= 8'h00;
            value       <= '0;
            value_valid <= 1'b0;
            err_cnt     <= 8'h00;
        end else begin
            r_shoot_d   <= shoot;
            value_valid <= w_commit;

            if ((r_state == ST_STARTUP) && !w_su_done) begin
                r_su_cnt <= r_su_cnt + c_SU_W'(1);
            end

            // Inter-byte timer only runs while a frame is partially received
            if (rx_done || w_nak) begin
                r_tmr <= '0;
            end else if ((r_state == ST_RECV) && (r_idx != '0)) begin
                r_tmr <= r_tmr + c_TMR_W'(1);
            end

            if (w_nak || w_last) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end

            // First byte of a frame lands in the most significant slot
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (w_accept && (r_idx == c_IDX_W'(NUM_BYTES - 1 - b))) begin
                    r_shadow[8*b +: 8] <= rx_data;
                end
            end

            if ((r_state == ST_RECV) && (w_state_next == ST_REPLY)) begin
                tx_data <= w_nak ? NAK_BYTE : ACK_BYTE;
                r_ack   <= !w_nak;
            end

            if (w_commit) begin
                value <= r_shadow;
            end

            if (w_err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_ctrl
//  Description : Self-checking bench for uart_frame_ctrl (2-byte frames,
//                short startup and timeout). Replies and commits are checked
//                against a queue of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        shoot;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_parity_err;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] value;
    logic        value_valid;
    logic [7:0]  err_cnt;
    logic        armed;

    int n_vec = 0;
    int n_err = 0;
    int n_tx  = 0;
    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_val_q[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        p0;
        logic        p1;
        logic [7:0]  exp_tx;
        logic        commit;
        logic [15:0] exp_value;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl[5];

    uart_frame_ctrl #(
        .NUM_BYTES      (2),
        .STARTUP_CYCLES (10),
        .TIMEOUT_CYCLES (50),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .shoot         (shoot),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .value         (value),
        .value_valid   (value_valid),
        .err_cnt       (err_cnt),
        .armed         (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every reply pulse and commit pulse consumes one expected entry
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_tx++;
            if (exp_tx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got tx_start=1 tx_data=%0h, expected no reply", tx_data);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            end
        end
        if (value_valid === 1'b1) begin
            if (exp_val_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL commit_unexpected: got value_valid=1 value=%0h, expected no commit", value);
            end else begin
                check("commit_value", {16'h0, value}, {16'h0, exp_val_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr);
        rx_data       = b;
        rx_parity_err = perr;
        rx_done       = 1'b1;
        tick();
        rx_done       = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    task automatic shoot_edge();
        shoot = 1'b0;
        tick();
        shoot = 1'b1;
        tick();
        tick();
        shoot = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 100;
        while ((exp_tx_q.size() != 0 || exp_val_q.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL %s: got %0d replies and %0d commits pending, expected 0",
                     name, exp_tx_q.size(), exp_val_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tx_before;

        tbl[0] = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h06, 1'b1, 16'h1122, 8'd1};
        tbl[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 8'h15, 1'b0, 16'h1122, 8'd2};
        tbl[2] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h15, 1'b0, 16'h1122, 8'd3};
        tbl[3] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h06, 1'b1, 16'h0001, 8'd3};
        tbl[4] = '{8'hDE, 8'hAD, 1'b0, 1'b0, 8'h06, 1'b1, 16'hDEAD, 8'd3};

        reset = 1'b1; shoot = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
        rx_parity_err = 1'b0; tx_busy = 1'b0;
        repeat (3) tick();
        check("reset_armed",   {31'h0, armed},       32'h0);
        check("reset_txstart", {31'h0, tx_start},    32'h0);
        check("reset_txdata",  {24'h0, tx_data},     32'h0);
        check("reset_value",   {16'h0, value},       32'h0);
        check("reset_valid",   {31'h0, value_valid}, 32'h0);
        check("reset_errcnt",  {24'h0, err_cnt},     32'h0);

        // Startup hold-off with bytes arriving that must be ignored
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("startup_armed_low", {31'h0, armed}, 32'h0);
            rx_data = 8'($urandom);
            rx_done = 1'b1;
            tick();
        end
        rx_done = 1'b0;
        tick();
        check("startup_armed_high", {31'h0, armed}, 32'h1);
        check("startup_errcnt", {24'h0, err_cnt}, 32'h0);

        // Good frame, then commit
        exp_tx_q.push_back(8'h06);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        exp_val_q.push_back(16'hA53C);
        shoot_edge();
        drain("ack_frame");
        check("ack_frame_value", {16'h0, value}, 32'h0000A53C);

        // Parity error, then a good frame
        exp_tx_q.push_back(8'h15);
        send_byte(8'h12, 1'b1);
        tick();
        drain("nak_reply");
        check("nak_errcnt", {24'h0, err_cnt}, 32'h1);
        check("nak_value_held", {16'h0, value}, 32'h0000A53C);
        exp_tx_q.push_back(8'h06);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_val_q.push_back(16'h0102);
        shoot_edge();
        drain("after_nak_frame");
        check("after_nak_value", {16'h0, value}, 32'h00000102);

        // Table of frames: good, parity on last byte, parity on first byte
        for (int i = 0; i < 5; i++) begin
            exp_tx_q.push_back(tbl[i].exp_tx);
            send_byte(tbl[i].b0, tbl[i].p0);
            if (!tbl[i].p0) begin
                send_byte(tbl[i].b1, tbl[i].p1);
            end
            tick();
            if (tbl[i].commit) begin
                exp_val_q.push_back(tbl[i].exp_value);
                shoot_edge();
            end
            drain("table_row");
            check("table_value",  {16'h0, value},   {16'h0, tbl[i].exp_value});
            check("table_errcnt", {24'h0, err_cnt}, {24'h0, tbl[i].exp_err});
        end

        // Inter-byte timeout after 50 idle cycles
        tx_before = n_tx;
        exp_tx_q.push_back(8'h15);
        send_byte(8'h99, 1'b0);
        repeat (50) tick();
        @(negedge clk);
        #1;
        check("timeout_not_early", n_tx - tx_before, 32'h0);
        tick();
        drain("timeout_nak");
        check("timeout_errcnt", {24'h0, err_cnt}, 32'h4);

        // Byte arriving in the expiry cycle is accepted
        exp_tx_q.push_back(8'h06);
        send_byte(8'h5A, 1'b0);
        repeat (50) tick();
        send_byte(8'hC3, 1'b0);
        exp_val_q.push_back(16'h5AC3);
        shoot_edge();
        drain("expiry_race");
        check("expiry_errcnt", {24'h0, err_cnt}, 32'h4);
        check("expiry_value", {16'h0, value}, 32'h00005AC3);

        // Transmitter busy at reply time; bytes dropped in REPLY and HOLD
        tx_busy = 1'b1;
        exp_tx_q.push_back(8'h06);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        tx_before = n_tx;
        repeat (10) tick();
        send_byte(8'h77, 1'b0);
        repeat (9) tick();
        check("busy_no_txstart", n_tx - tx_before, 32'h0);
        tx_busy = 1'b0;
        tick();
        check("busy_one_txstart", n_tx - tx_before, 32'h1);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("hold_errcnt", {24'h0, err_cnt}, 32'h8);
        exp_val_q.push_back(16'h1020);
        shoot_edge();
        drain("busy_frame");
        check("busy_value", {16'h0, value}, 32'h00001020);

        // Reset after the first byte of a frame
        send_byte(8'h44, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check("midreset_value",  {16'h0, value},   32'h0);
        check("midreset_errcnt", {24'h0, err_cnt}, 32'h0);
        check("midreset_armed",  {31'h0, armed},   32'h0);
        shoot = 1'b1;
        reset = 1'b0;
        repeat (12) tick();
        check("midreset_rearmed", {31'h0, armed}, 32'h1);
        exp_tx_q.push_back(8'h06);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_val_q.push_back(16'hFF00);
        shoot_edge();
        drain("postreset_frame");
        check("postreset_value", {16'h0, value}, 32'h0000FF00);

        // Error counter saturation using bytes dropped in HOLD
        exp_tx_q.push_back(8'h06);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        tick();
        rx_data = 8'h5C;
        rx_done = 1'b1;
        repeat (260) tick();
        rx_done = 1'b0;
        check("errcnt_saturate", {24'h0, err_cnt}, 32'hFF);
        exp_val_q.push_back(16'h0102);
        shoot_edge();
        drain("saturate_frame");
        check("saturate_value", {16'h0, value}, 32'h00000102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
